// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC and handles opcode+immediate pairs, stalls, redirects and halt.
// PC and state are registered. The valid and flush enables are decoded combinationally for the same-cycle read.
module fetch_ctrl #(
  parameter int unsigned           PC_W     = 16,
  parameter logic [PC_W-1:0]       RESET_PC = 'd32,
  parameter int unsigned           IMM_BIT  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic            halt_i,
  input  logic [15:0]     instr_i,
  output logic [PC_W-1:0] pc_o,
  output logic            instr_valid_o,
  output logic            imm_valid_o,
  output logic            flush_o,
  output logic            halted_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_IMM   = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [PC_W-1:0] pc, next_pc;
  logic [PC_W-1:0] pc_inc;

  // Wraps modulo 2^PC_W by construction.
  assign pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= next_state;
      pc    <= next_pc;
    end
  end

  // Redirect beats halt, halt beats stall; HALT is left only by a redirect.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    if (branch_taken_i) begin
      next_state = S_FETCH;
      next_pc    = branch_target_i;
    end else if (halt_i) begin
      next_state = S_HALT;
    end else if (state == S_HALT || stall_i) begin
      next_state = state;
    end else begin
      next_pc = pc_inc;
      case (state)
        S_FETCH: next_state = instr_i[IMM_BIT] ? S_IMM : S_FETCH;
        S_IMM:   next_state = S_FETCH;
        default: next_state = S_FETCH;
      endcase
    end
  end

  always_comb begin
    instr_valid_o = 1'b0;
    imm_valid_o   = 1'b0;
    flush_o       = 1'b0;
    if (reset || branch_taken_i) begin
      flush_o = 1'b1;
    end else if (state != S_HALT && !halt_i && !stall_i) begin
      instr_valid_o = (state == S_FETCH);
      imm_valid_o   = (state == S_IMM);
    end
  end

  assign pc_o     = pc;
  assign halted_o = (state == S_HALT) && !reset;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a combinational instruction-memory model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        instr_valid;
  logic        imm_valid;
  logic        flush;
  logic        halted;

  logic [15:0] mem [0:65535];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign instr = mem[pc];

  fetch_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .halt_i          (halt),
    .instr_i         (instr),
    .pc_o            (pc),
    .instr_valid_o   (instr_valid),
    .imm_valid_o     (imm_valid),
    .flush_o         (flush),
    .halted_o        (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock, then leave inputs a settle window before checks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] e_pc, input logic e_iv,
                            input logic e_mv, input logic e_fl, input logic e_h);
    #1;
    check({tag, ".pc"},    32'(pc),          32'(e_pc));
    check({tag, ".ivld"},  32'(instr_valid), 32'(e_iv));
    check({tag, ".mvld"},  32'(imm_valid),   32'(e_mv));
    check({tag, ".flush"}, 32'(flush),       32'(e_fl));
    check({tag, ".halt"},  32'(halted),      32'(e_h));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[32] = 16'h0010; mem[33] = 16'h0020; mem[34] = 16'h0030; mem[35] = 16'h0040;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000; halt = 1'b0;

    // 1: reset then straight-line 1-word ops
    #1;
    check("rst.flush", 32'(flush), 32'd1);
    check("rst.ivld",  32'(instr_valid), 32'd0);
    check("rst.halt",  32'(halted), 32'd0);
    step();
    expect_out("rst1", 16'd32, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    reset = 1'b0;
    expect_out("seq32", 16'd32, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); expect_out("seq33", 16'd33, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); expect_out("seq34", 16'd34, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); expect_out("seq35", 16'd35, 1'b1, 1'b0, 1'b0, 1'b0);

    // 2: opcode with immediate flag, immediate word itself has bit0 set
    mem[32] = 16'h0011; mem[33] = 16'hBEEF; mem[34] = 16'h0000;
    reset = 1'b1; step(); reset = 1'b0;
    expect_out("imm.op",   16'd32, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); expect_out("imm.word", 16'd33, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("imm.next", 16'd34, 1'b1, 1'b0, 1'b0, 1'b0);

    // 3: stall held three cycles in IMM
    reset = 1'b1; step(); reset = 1'b0;
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_out("stall.imm", 16'd33, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    stall = 1'b0;
    expect_out("stall.rel", 16'd33, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); expect_out("stall.next", 16'd34, 1'b1, 1'b0, 1'b0, 1'b0);

    // 4: branch together with stall while in IMM
    reset = 1'b1; step(); reset = 1'b0;
    step();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0100;
    expect_out("br.imm", 16'd33, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    stall = 1'b0; branch_taken = 1'b0;
    expect_out("br.tgt", 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0);

    // 5: halt at pc 40, idle, then branch out
    branch_taken = 1'b1; branch_target = 16'd40;
    step();
    branch_taken = 1'b0; halt = 1'b1; stall = 1'b1;
    expect_out("halt.req", 16'd40, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    halt = 1'b0; stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_out("halt.idle", 16'd40, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    branch_taken = 1'b1; branch_target = 16'h0050;
    expect_out("halt.br", 16'd40, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    branch_taken = 1'b0;
    expect_out("halt.exit", 16'h0050, 1'b1, 1'b0, 1'b0, 1'b0);

    // 6: PC wrap, then reset in the middle of an immediate
    mem[16'h0000] = 16'h0001;
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    step();
    branch_taken = 1'b0;
    expect_out("wrap.ffff", 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); expect_out("wrap.zero", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    expect_out("rst.imm", 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    reset = 1'b0;
    expect_out("rst.back", 16'd32, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
